// File: rtl/bus_port_fifo.sv
// bus_port_fifo: bus port with a tx FIFO toward the bus, an address-filtered rx FIFO from the bus,
// and saturating drop / misroute counters.
module bus_port_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth = 8,
  parameter logic [7:0] drv_id = 8'd0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               wr_en,
  input  logic [pckg_sz-1:0] wr_data,
  output logic               tx_full,
  input  logic               rd_en,
  output logic [pckg_sz-1:0] rd_data,
  output logic               rx_valid,
  output logic               rx_full,
  output logic [7:0]         drop_cnt,
  output logic [7:0]         misroute_cnt
);
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  logic [pckg_sz-1:0] tx_mem_q [depth];
  logic [pckg_sz-1:0] rx_mem_q [depth];
  logic [aw-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [cw-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0] drop_q, drop_d, mis_q, mis_d;
  logic [8:0] drop_sum;
  logic tx_pop, tx_wr, tx_drop, rx_match, rx_rd, rx_wr, rx_drop, rx_mis;
  always_comb begin
    pndng = tx_cnt_q != '0;
    tx_full = tx_cnt_q == cw'(depth);
    rx_valid = rx_cnt_q != '0;
    rx_full = rx_cnt_q == cw'(depth);
    D_pop = tx_mem_q[tx_rd_q];
    rd_data = rx_mem_q[rx_rd_q];
    drop_cnt = drop_q;
    misroute_cnt = mis_q;
    tx_pop = pop && pndng;
    tx_wr = wr_en && (!tx_full || pop);
    tx_drop = wr_en && tx_full && !pop;
    rx_match = D_push[pckg_sz-1 -: 8] == drv_id || D_push[pckg_sz-1 -: 8] == 8'hFF;
    rx_rd = rd_en && rx_valid;
    rx_wr = push && rx_match && (!rx_full || rd_en);
    rx_drop = push && rx_match && rx_full && !rd_en;
    rx_mis = push && !rx_match;
    tx_wr_d = tx_wr ? tx_wr_q + aw'(1) : tx_wr_q;
    tx_rd_d = tx_pop ? tx_rd_q + aw'(1) : tx_rd_q;
    rx_wr_d = rx_wr ? rx_wr_q + aw'(1) : rx_wr_q;
    rx_rd_d = rx_rd ? rx_rd_q + aw'(1) : rx_rd_q;
    tx_cnt_d = tx_cnt_q + cw'(tx_wr) - cw'(tx_pop);
    rx_cnt_d = rx_cnt_q + cw'(rx_wr) - cw'(rx_rd);
    // both paths may drop in one cycle, so sum in 9 bits before clamping
    drop_sum = {1'b0, drop_q} + 9'(tx_drop) + 9'(rx_drop);
    drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    mis_d = (rx_mis && mis_q != 8'hFF) ? mis_q + 8'd1 : mis_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      drop_q <= '0;
      mis_q <= '0;
    end else begin
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      drop_q <= drop_d;
      mis_q <= mis_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && tx_wr) tx_mem_q[tx_wr_q] <= wr_data;
    if (!reset && rx_wr) rx_mem_q[rx_wr_q] <= D_push;
  end
endmodule

// File: tb/tb_bus_port_fifo.sv
// tb_bus_port_fifo: queue-based reference model with a decoupled scoreboard monitor.
module tb_bus_port_fifo;
  localparam int P = 16;
  localparam int D = 8;
  localparam logic [7:0] ID = 8'd3;
  logic clk = 0, reset = 1, pop = 0, push = 0, wr_en = 0, rd_en = 0;
  logic [P-1:0] D_push = '0, wr_data = '0;
  logic pndng, tx_full, rx_valid, rx_full;
  logic [P-1:0] D_pop, rd_data;
  logic [7:0] drop_cnt, misroute_cnt;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic pndng, txf, rxv, rxf;
    logic [P-1:0] head, rhead;
    logic [7:0] drop, mis;
  } exp_t;
  exp_t exp_q[$];
  logic [P-1:0] txm[$], rxm[$], pop_q[$], rd_q[$];
  int drop_m = 0, mis_m = 0;

  bus_port_fifo #(.pckg_sz(P), .depth(D), .drv_id(ID)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .rd_en(rd_en),
    .rd_data(rd_data), .rx_valid(rx_valid), .rx_full(rx_full), .drop_cnt(drop_cnt),
    .misroute_cnt(misroute_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [P-1:0] a, input logic [P-1:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic we, input logic [P-1:0] wd, input logic p,
                     input logic ps, input logic [P-1:0] dp, input logic re);
    exp_t e;
    logic match, tdrop, rdrop;
    reset = r; wr_en = we; wr_data = wd; pop = p; push = ps; D_push = dp; rd_en = re;
    e.pndng = txm.size() != 0;
    e.txf = txm.size() == D;
    e.rxv = rxm.size() != 0;
    e.rxf = rxm.size() == D;
    e.head = e.pndng ? txm[0] : '0;
    e.rhead = e.rxv ? rxm[0] : '0;
    e.drop = 8'(drop_m);
    e.mis = 8'(mis_m);
    exp_q.push_back(e);
    if (r) begin
      txm.delete(); rxm.delete(); drop_m = 0; mis_m = 0;
    end else begin
      tdrop = we && txm.size() == D && !p;
      if (p && txm.size() != 0) pop_q.push_back(txm.pop_front());
      if (we && !tdrop) txm.push_back(wd);
      match = dp[P-1 -: 8] == ID || dp[P-1 -: 8] == 8'hFF;
      rdrop = ps && match && rxm.size() == D && !re;
      if (re && rxm.size() != 0) rd_q.push_back(rxm.pop_front());
      if (ps && !match) mis_m = mis_m == 255 ? 255 : mis_m + 1;
      else if (ps && !rdrop) rxm.push_back(dp);
      drop_m = drop_m + int'(tdrop) + int'(rdrop);
      if (drop_m > 255) drop_m = 255;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, '0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pndng", P'(pndng), P'(e.pndng));
        chk("tx_full", P'(tx_full), P'(e.txf));
        chk("rx_valid", P'(rx_valid), P'(e.rxv));
        chk("rx_full", P'(rx_full), P'(e.rxf));
        chk("drop_cnt", P'(drop_cnt), P'(e.drop));
        chk("misroute_cnt", P'(misroute_cnt), P'(e.mis));
        if (e.pndng) chk("D_pop", D_pop, e.head);
        if (e.rxv) chk("rd_data", rd_data, e.rhead);
        if (!reset && pop && pndng) begin
          if (pop_q.size() != 0) chk("popped", D_pop, pop_q.pop_front());
          else chk("unexpected_pop", 16'h1, 16'h0);
        end
        if (!reset && rd_en && rx_valid) begin
          if (rd_q.size() != 0) chk("read", rd_data, rd_q.pop_front());
          else chk("unexpected_read", 16'h1, 16'h0);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] a;
    repeat (2) @(posedge clk);
    #1;
    cyc(1, 0, '0, 0, 0, '0, 0);
    idle(1);
    for (int i = 1; i <= 3; i++) cyc(0, 1, 16'h0A00 + P'(i), 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1, 0, '0, 0);
    idle(1);
    for (int i = 0; i < 9; i++) cyc(0, 1, 16'h1100 + P'(i), 0, 0, '0, 0);
    cyc(0, 1, 16'h2222, 1, 0, '0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, '0, 1, 0, '0, 0);
    cyc(0, 1, 16'h3333, 1, 0, '0, 0);
    cyc(0, 0, '0, 1, 0, '0, 0);
    cyc(0, 0, '0, 0, 1, 16'h0355, 0);
    cyc(0, 0, '0, 0, 1, 16'h0466, 0);
    cyc(0, 0, '0, 0, 1, 16'hFF77, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 0, '0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, '0, 0, 1, 16'h0300 + P'(i), 0);
    cyc(0, 0, '0, 0, 1, 16'h03AA, 1);
    for (int i = 0; i < 9; i++) cyc(0, 0, '0, 0, 0, '0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 16'h4400 + P'(i), 0, 1, 16'hFF00 + P'(i), 0);
    cyc(0, 1, 16'h4499, 0, 1, 16'h0399, 0);
    cyc(1, 0, '0, 0, 0, '0, 0);
    for (int i = 0; i < 300; i++) cyc(0, 0, '0, 0, 1, 16'h0100 + P'(i % 200), 0);
    cyc(1, 1, 16'hDEAD, 1, 1, 16'h0312, 1);
    idle(1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 16'h5500 + P'(i), 0, 0, '0, 0);
    cyc(1, 0, '0, 0, 0, '0, 0);
    cyc(0, 1, 16'h0B0B, 0, 0, '0, 0);
    cyc(0, 0, '0, 1, 0, '0, 0);
    idle(1);
    for (int ph = 0; ph < 4; ph++)
      for (int i = 0; i < 600; i++) begin
        case ($urandom_range(0, 2))
          0: a = ID;
          1: a = 8'hFF;
          default: a = 8'($urandom);
        endcase
        cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) < 2 + ph % 2,
            P'($urandom), $urandom_range(0, 3) < 2 - ph % 2 + ph / 2,
            $urandom_range(0, 3) < 2 + ph % 2, {a, 8'($urandom)},
            $urandom_range(0, 3) < 2 - ph % 2 + ph / 2);
      end
    idle(2);
    @(negedge clk);
    chk("scoreboard_drained", P'(exp_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
